// File: rtl/rv_alu_pkg.sv
// Shared definitions for the rv_alu datapath and its two-port arbiter:
// op-select codes, slot FSM encoding and default datapath width.
package rv_alu_pkg;

    localparam int ALU_XLEN = 64;
    localparam int ALU_SELW = 4;

    localparam logic [ALU_SELW-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_SELW-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_SELW-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_SELW-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_SELW-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_SELW-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_EXEC = 2'd1,
        SLOT_RESP = 2'd2
    } slot_state_e;

endpackage

// File: rtl/rv_alu.sv
// Purely combinational 64-bit ALU: and/or/add/sub/unsigned-slt/nor.
// Unsupported select codes produce zero.
module rv_alu
    import rv_alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int SELW = ALU_SELW
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [SELW-1:0] sel_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (sel_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_NOR: result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_alu_arb.sv
// Two-port arbiter/sequencer in front of one shared rv_alu instance.
// Define ALU_ARB_RR_EN for round-robin tie-break; default is fixed priority (port 0).
//
// state     | meaning
// SLOT_IDLE | no op outstanding, port may be accepted
// SLOT_EXEC | op sits in S1, ALU evaluating this cycle
// SLOT_RESP | result held in response buffer until rsp handshake
module rv_alu_arb
    import rv_alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int SELW = ALU_SELW
) (
    input  logic            clk_i,
    input  logic            rst_n_i,

    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [XLEN-1:0] req0_op1_i,
    input  logic [XLEN-1:0] req0_op2_i,
    input  logic [SELW-1:0] req0_sel_i,
    output logic            rsp0_valid_o,
    input  logic            rsp0_ready_i,
    output logic [XLEN-1:0] rsp0_result_o,

    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [XLEN-1:0] req1_op1_i,
    input  logic [XLEN-1:0] req1_op2_i,
    input  logic [SELW-1:0] req1_sel_i,
    output logic            rsp1_valid_o,
    input  logic            rsp1_ready_i,
    output logic [XLEN-1:0] rsp1_result_o
);

    slot_state_e     slot0_q, slot0_d;
    slot_state_e     slot1_q, slot1_d;

    logic [XLEN-1:0] s1_op1_q, s1_op2_q;
    logic [SELW-1:0] s1_sel_q;
    logic            s1_owner_q;

    logic [XLEN-1:0] rsp0_q, rsp1_q;
    logic [XLEN-1:0] alu_result;

    logic            elig0, elig1;
    logic            grant0, grant1;
    logic            acc0, acc1;

    assign elig0 = req0_valid_i && (slot0_q == SLOT_IDLE);
    assign elig1 = req1_valid_i && (slot1_q == SLOT_IDLE);

`ifdef ALU_ARB_RR_EN
    logic last_q;

    // On a tie, port 1 wins only if port 0 was granted last.
    assign grant1 = elig1 && (!elig0 || (last_q == 1'b0));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else if (acc0) begin
            last_q <= 1'b0;
        end else if (acc1) begin
            last_q <= 1'b1;
        end
    end
`else
    assign grant1 = elig1 && !elig0;
`endif

    assign grant0 = elig0 && !grant1;

    // Gate with reset so neither port sees ready while reset is held.
    assign req0_ready_o = rst_n_i && grant0;
    assign req1_ready_o = rst_n_i && grant1;
    assign acc0         = req0_valid_i && req0_ready_o;
    assign acc1         = req1_valid_i && req1_ready_o;

    always_comb begin
        slot0_d = slot0_q;
        case (slot0_q)
            SLOT_IDLE: if (acc0)         slot0_d = SLOT_EXEC;
            SLOT_EXEC:                   slot0_d = SLOT_RESP;
            SLOT_RESP: if (rsp0_ready_i) slot0_d = SLOT_IDLE;
            default:                     slot0_d = SLOT_IDLE;
        endcase

        slot1_d = slot1_q;
        case (slot1_q)
            SLOT_IDLE: if (acc1)         slot1_d = SLOT_EXEC;
            SLOT_EXEC:                   slot1_d = SLOT_RESP;
            SLOT_RESP: if (rsp1_ready_i) slot1_d = SLOT_IDLE;
            default:                     slot1_d = SLOT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            slot0_q <= SLOT_IDLE;
            slot1_q <= SLOT_IDLE;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // S1 can be reloaded on the same edge its current op finishes, since the
    // result capture below still sees the old S1 contents.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_op1_q   <= '0;
            s1_op2_q   <= '0;
            s1_sel_q   <= '0;
            s1_owner_q <= 1'b0;
        end else if (acc0) begin
            s1_op1_q   <= req0_op1_i;
            s1_op2_q   <= req0_op2_i;
            s1_sel_q   <= req0_sel_i;
            s1_owner_q <= 1'b0;
        end else if (acc1) begin
            s1_op1_q   <= req1_op1_i;
            s1_op2_q   <= req1_op2_i;
            s1_sel_q   <= req1_sel_i;
            s1_owner_q <= 1'b1;
        end
    end

    rv_alu #(
        .XLEN (XLEN),
        .SELW (SELW)
    ) u_alu (
        .a_i      (s1_op1_q),
        .b_i      (s1_op2_q),
        .sel_i    (s1_sel_q),
        .result_o (alu_result)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rsp0_q <= '0;
            rsp1_q <= '0;
        end else begin
            if (slot0_q == SLOT_EXEC && s1_owner_q == 1'b0) rsp0_q <= alu_result;
            if (slot1_q == SLOT_EXEC && s1_owner_q == 1'b1) rsp1_q <= alu_result;
        end
    end

    assign rsp0_valid_o  = (slot0_q == SLOT_RESP);
    assign rsp1_valid_o  = (slot1_q == SLOT_RESP);
    assign rsp0_result_o = rsp0_q;
    assign rsp1_result_o = rsp1_q;

endmodule

// File: tb/tb_rv_alu_arb.sv
// Directed self-checking bench for rv_alu_arb (either tie-break build).
module tb_rv_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [63:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [63:0] rsp0_result, rsp1_result;
    logic [3:0]  req0_sel, req1_sel;

    int checks = 0;
    int errors = 0;

    logic [63:0] tv_a   [8];
    logic [63:0] tv_b   [8];
    logic [3:0]  tv_sel [8];
    logic [63:0] tv_exp [8];

    always #5 clk = ~clk;

    rv_alu_arb dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req0_valid_i  (req0_valid),
        .req0_ready_o  (req0_ready),
        .req0_op1_i    (req0_op1),
        .req0_op2_i    (req0_op2),
        .req0_sel_i    (req0_sel),
        .rsp0_valid_o  (rsp0_valid),
        .rsp0_ready_i  (rsp0_ready),
        .rsp0_result_o (rsp0_result),
        .req1_valid_i  (req1_valid),
        .req1_ready_o  (req1_ready),
        .req1_op1_i    (req1_op1),
        .req1_op2_i    (req1_op2),
        .req1_sel_i    (req1_sel),
        .rsp1_valid_o  (rsp1_valid),
        .rsp1_ready_i  (rsp1_ready),
        .rsp1_result_o (rsp1_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] s);
        if (p == 0) begin
            req0_valid = v; req0_op1 = a; req0_op2 = b; req0_sel = s;
        end else begin
            req1_valid = v; req1_op1 = a; req1_op2 = b; req1_sel = s;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b1, 64'd9, 64'd9, 4'b0010);
        set_req(1, 1'b1, 64'd7, 64'd7, 4'b0010);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid});
        end
        checks++;
        if (rsp0_result !== 64'd0 || rsp1_result !== 64'd0) begin
            errors++; $display("FAIL reset_result got %h/%h want 0/0", rsp0_result, rsp1_result);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL first_grant got %b want 10", {req0_ready, req1_ready});
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        tick();
    endtask

    task automatic test_latency();
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 64'd5, 64'd3, 4'b0010);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL lat_accept got %b want 1", req0_ready);
        end
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL lat_exec_valid got %b want 0", rsp0_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 64'd8) begin
            errors++; $display("FAIL lat_add got v=%b r=%h want v=1 r=8", rsp0_valid, rsp0_result);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 64'd1, 64'd1, 4'b0010);
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0 || req0_ready !== 1'b1) begin
            errors++; $display("FAIL lat_reissue got v=%b rdy=%b want v=0 rdy=1", rsp0_valid, req0_ready);
        end
        set_req(0, 1'b0, '0, '0, '0);
        tick();
    endtask

    task automatic test_ops_p1();
        tv_a[0] = 64'd0;                  tv_b[0] = 64'd1;                  tv_sel[0] = 4'b0110; tv_exp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        tv_a[1] = 64'd1;                  tv_b[1] = 64'd2;                  tv_sel[1] = 4'b0111; tv_exp[1] = 64'd1;
        tv_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; tv_b[2] = 64'd1;                 tv_sel[2] = 4'b0111; tv_exp[2] = 64'd0;
        tv_a[3] = 64'hFFFF_FFFF_FFFF_FFFF; tv_b[3] = 64'd1;                 tv_sel[3] = 4'b0010; tv_exp[3] = 64'd0;
        tv_a[4] = 64'hF0F0_F0F0_F0F0_F0F0; tv_b[4] = 64'h0FF0_0FF0_0FF0_0FF0; tv_sel[4] = 4'b0000; tv_exp[4] = 64'h00F0_00F0_00F0_00F0;
        tv_a[5] = 64'hF0F0_F0F0_F0F0_F0F0; tv_b[5] = 64'h0FF0_0FF0_0FF0_0FF0; tv_sel[5] = 4'b0001; tv_exp[5] = 64'hFFF0_FFF0_FFF0_FFF0;
        tv_a[6] = 64'hF0F0_F0F0_F0F0_F0F0; tv_b[6] = 64'h0FF0_0FF0_0FF0_0FF0; tv_sel[6] = 4'b1100; tv_exp[6] = 64'h000F_000F_000F_000F;
        tv_a[7] = 64'd5;                  tv_b[7] = 64'd3;                  tv_sel[7] = 4'b1111; tv_exp[7] = 64'd0;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1'b1, tv_a[i], tv_b[i], tv_sel[i]);
            @(negedge clk);
            checks++;
            if (req1_ready !== 1'b1) begin
                errors++; $display("FAIL op%0d_accept got %b want 1", i, req1_ready);
            end
            tick();
            set_req(1, 1'b0, '0, '0, '0);
            @(negedge clk);
            checks++;
            if (rsp1_valid !== 1'b0) begin
                errors++; $display("FAIL op%0d_exec_valid got %b want 0", i, rsp1_valid);
            end
            tick();
            @(negedge clk);
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_result !== tv_exp[i]) begin
                errors++; $display("FAIL op%0d_result got v=%b r=%h want v=1 r=%h", i, rsp1_valid, rsp1_result, tv_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_tie();
        logic [1:0] exp_rdy;
        do_reset();
        set_req(0, 1'b1, 64'd1, 64'd1, 4'b0010);
        @(negedge clk);
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        tick();
        tick();
        set_req(0, 1'b1, 64'd2, 64'd2, 4'b0010);
        set_req(1, 1'b1, 64'd3, 64'd3, 4'b0010);
`ifdef ALU_ARB_RR_EN
        exp_rdy = 2'b01;
`else
        exp_rdy = 2'b10;
`endif
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== exp_rdy) begin
            errors++; $display("FAIL tie_grant got %b want %b", {req0_ready, req1_ready}, exp_rdy);
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        tick();
    endtask

    task automatic test_back_to_back();
        int code;
        do_reset();
        set_req(0, 1'b1, 64'd10, 64'd20, 4'b0010);
        set_req(1, 1'b1, 64'd7, 64'd2, 4'b0110);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            code = req0_ready ? 0 : (req1_ready ? 1 : 2);
            checks++;
            if ((req0_ready && req1_ready) || code != (c % 3)) begin
                errors++; $display("FAIL b2b_cycle%0d got rdy=%b%b want code %0d", c, req0_ready, req1_ready, c % 3);
            end
            if (rsp0_valid) begin
                checks++;
                if (rsp0_result !== 64'd30) begin
                    errors++; $display("FAIL b2b_rsp0 got %h want 1e", rsp0_result);
                end
            end
            if (rsp1_valid) begin
                checks++;
                if (rsp1_result !== 64'd5) begin
                    errors++; $display("FAIL b2b_rsp1 got %h want 5", rsp1_result);
                end
            end
            tick();
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int p1_done;
        int bad;
        p1_done = 0;
        bad = 0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 64'h1000, 64'h0234, 4'b0010);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_accept got %b want 1", req0_ready);
        end
        tick();
        set_req(0, 1'b1, 64'd5, 64'd3, 4'b1111);
        set_req(1, 1'b1, 64'd1, 64'd1, 4'b0010);
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp0_valid !== 1'b1 || rsp0_result !== 64'h1234 || req0_ready !== 1'b0) bad++;
            if (rsp1_valid === 1'b1) begin
                p1_done++;
                checks++;
                if (rsp1_result !== 64'd2) begin
                    errors++; $display("FAIL bp_p1_result got %h want 2", rsp1_result);
                end
            end
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        checks++;
        if (p1_done != 3) begin
            errors++; $display("FAIL bp_p1_progress got %0d responses want 3", p1_done);
        end
        set_req(1, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_accept got %b want 1", req0_ready);
        end
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        tick();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 64'd0) begin
            errors++; $display("FAIL bp_unsup_sel got v=%b r=%h want v=1 r=0", rsp0_valid, rsp0_result);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        rsp1_ready = 1'b0;
        set_req(1, 1'b1, 64'd3, 64'd4, 4'b0010);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL mid_accept got %b want 1", req1_ready);
        end
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready_in_reset got %b want 0", req1_ready);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL mid_after_release got rdy=%b v=%b want rdy=1 v=0", req1_ready, rsp1_valid);
        end
        set_req(1, 1'b0, '0, '0, '0);
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            if (rsp1_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_no_rsp got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        #1;
        test_reset();
        test_latency();
        test_ops_p1();
        test_tie();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
